// File: rtl/fp_align_stage_pkg.sv
// Shared widths, state encoding and IEEE-754 single field helpers for the float_adder datapath.
// Reused by the align, normalize and round stages.
package fp_align_stage_pkg;

  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int GRS_W  = 3;
  localparam int MANT_W = MAN_W + 1 + GRS_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPARE,
    S_SHIFT,
    S_DONE
  } state_t;

  function automatic logic f_sign(input logic [31:0] w);
    return w[31];
  endfunction

  function automatic logic [EXP_W-1:0] f_exp(input logic [31:0] w);
    return w[30:23];
  endfunction

  function automatic logic [MAN_W-1:0] f_frac(input logic [31:0] w);
    return w[22:0];
  endfunction

endpackage

// File: rtl/fp_align_stage_if.sv
// Operand/result handshake bundle of the align stage.
// The master side feeds operands and consumes aligned results; the slave side is the stage.
interface fp_align_stage_if;
  import fp_align_stage_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [31:0]       x;
  logic [31:0]       y;
  logic              out_valid;
  logic              out_ready;
  logic              swap;
  logic              big_sign;
  logic              eff_sub;
  logic [EXP_W-1:0]  exp_out;
  logic [MANT_W-1:0] man_big;
  logic [MANT_W-1:0] man_small;

  modport master (
    output in_valid, x, y, out_ready,
    input  in_ready, out_valid, swap, big_sign, eff_sub, exp_out, man_big, man_small
  );

  modport slave (
    input  in_valid, x, y, out_ready,
    output in_ready, out_valid, swap, big_sign, eff_sub, exp_out, man_big, man_small
  );

endinterface

// File: rtl/fp_align_stage_unpack.sv
// Combinational unpack of an IEEE-754 single into sign, effective exponent and 27-bit mantissa.
// Denormals get hidden bit 0 and an effective exponent of 1 so they align like exponent-1 values.
module fp_align_stage_unpack
  import fp_align_stage_pkg::*;
(
  input  logic [31:0]       word,
  output logic              sign,
  output logic [EXP_W-1:0]  exp_eff,
  output logic [MANT_W-1:0] mant
);

  logic [EXP_W-1:0] exp_raw;
  logic             hidden;

  assign exp_raw = f_exp(word);
  assign hidden  = (exp_raw != '0);
  assign sign    = f_sign(word);
  assign exp_eff = hidden ? exp_raw : EXP_W'(1);
  assign mant    = {hidden, f_frac(word), {GRS_W{1'b0}}};

endmodule

// File: rtl/fp_align_stage.sv
// Exponent compare and iterative mantissa alignment ahead of the operand-select mux.
// Build option FP_ALIGN_STICKY_EN: fold shifted-out bits into man_small[0]; otherwise truncate.
module fp_align_stage
  import fp_align_stage_pkg::*;
#(
  parameter int SHIFT_STEP = 4
) (
  input  logic            clk,
  input  logic            res,
  fp_align_stage_if.slave bus
);

  // state     | meaning
  // S_IDLE    | in_ready high, waiting for an operand pair
  // S_COMPARE | order operands by magnitude, load exponent difference
  // S_SHIFT   | shift man_small right by up to SHIFT_STEP per cycle
  // S_DONE    | out_valid high, outputs frozen until out_ready

  localparam logic [4:0] STEP = 5'(SHIFT_STEP);
  localparam logic [4:0] D_MAX = 5'(MANT_W);

  state_t            state;
  logic [31:0]       xr;
  logic [31:0]       yr;
  logic [4:0]        remaining;

  logic              sign_a, sign_b;
  logic [EXP_W-1:0]  exp_a, exp_b;
  logic [MANT_W-1:0] mant_a, mant_b;

  fp_align_stage_unpack u_unpack_a (.word(xr), .sign(sign_a), .exp_eff(exp_a), .mant(mant_a));
  fp_align_stage_unpack u_unpack_b (.word(yr), .sign(sign_b), .exp_eff(exp_b), .mant(mant_b));

  logic              swap_c;
  logic [EXP_W-1:0]  exp_diff;
  logic [4:0]        d_c;
  logic [4:0]        amt;
  logic [MANT_W-1:0] shifted;
  logic [MANT_W-1:0] shift_next;

  // Raw {exp,frac} comparison orders magnitudes exactly; ties keep x as the larger operand.
  assign swap_c   = yr[30:0] > xr[30:0];
  assign exp_diff = swap_c ? (exp_b - exp_a) : (exp_a - exp_b);
  assign d_c      = (exp_diff > EXP_W'(MANT_W)) ? D_MAX : exp_diff[4:0];

  always_comb begin
    amt        = (remaining > STEP) ? STEP : remaining;
    shifted    = bus.man_small >> amt;
    shift_next = shifted;
`ifdef FP_ALIGN_STICKY_EN
    shift_next[0] = shifted[0] | (|(bus.man_small & ~({MANT_W{1'b1}} << amt)));
`endif
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state         <= S_IDLE;
      xr            <= '0;
      yr            <= '0;
      remaining     <= '0;
      bus.in_ready  <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.swap      <= 1'b0;
      bus.big_sign  <= 1'b0;
      bus.eff_sub   <= 1'b0;
      bus.exp_out   <= '0;
      bus.man_big   <= '0;
      bus.man_small <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          bus.in_ready <= 1'b1;
          if (bus.in_valid && bus.in_ready) begin
            xr           <= bus.x;
            yr           <= bus.y;
            bus.in_ready <= 1'b0;
            state        <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          bus.swap      <= swap_c;
          bus.big_sign  <= swap_c ? sign_b : sign_a;
          bus.eff_sub   <= xr[31] ^ yr[31];
          bus.exp_out   <= swap_c ? exp_b : exp_a;
          bus.man_big   <= swap_c ? mant_b : mant_a;
          bus.man_small <= swap_c ? mant_a : mant_b;
          remaining     <= d_c;
          if (d_c == '0) begin
            bus.out_valid <= 1'b1;
            state         <= S_DONE;
          end else begin
            state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          bus.man_small <= shift_next;
          remaining     <= remaining - amt;
          if (remaining == amt) begin
            bus.out_valid <= 1'b1;
            state         <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_align_stage.sv
// Directed-vector bench for fp_align_stage: table of operand pairs plus stall and mid-shift reset sequences.
module tb_fp_align_stage;

  logic clk = 1'b0;
  logic res = 1'b1;
  always #5 clk = ~clk;

  fp_align_stage_if bus ();

  fp_align_stage #(.SHIFT_STEP(4)) dut (
    .clk (clk),
    .res (res),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        swap;
    logic        big_sign;
    logic        eff_sub;
    logic [7:0]  exp_out;
    logic [26:0] man_big;
    logic [26:0] small_sticky;
    logic [26:0] small_trunc;
    int          lat;
  } vec_t;

  vec_t vecs[10];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, req);
    end
  endtask

  function automatic logic [26:0] exp_small(input vec_t v);
`ifdef FP_ALIGN_STICKY_EN
    return v.small_sticky;
`else
    return v.small_trunc;
`endif
  endfunction

  // Drive one pair, return accept-to-valid latency counted in posedges (accept edge included).
  task automatic send(input logic [31:0] xv, input logic [31:0] yv, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    bus.x        = xv;
    bus.y        = yv;
    bus.in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    while (!bus.out_valid && lat < 60) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    chk({tag, " swap"}, 32'(bus.swap), 32'(v.swap));
    chk({tag, " big_sign"}, 32'(bus.big_sign), 32'(v.big_sign));
    chk({tag, " eff_sub"}, 32'(bus.eff_sub), 32'(v.eff_sub));
    chk({tag, " exp_out"}, 32'(bus.exp_out), 32'(v.exp_out));
    chk({tag, " man_big"}, 32'(bus.man_big), 32'(v.man_big));
    chk({tag, " man_small"}, 32'(bus.man_small), 32'(exp_small(v)));
  endtask

  task automatic handshake(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, " out_valid_after"}, 32'(bus.out_valid), 32'd0);
    chk({tag, " in_ready_after"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    int seen;
    vecs[0] = '{32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 1'b0, 8'h7F, 27'h4000000, 27'h4000000, 27'h4000000, 2};
    vecs[1] = '{32'h3F800000, 32'h40000000, 1'b1, 1'b0, 1'b0, 8'h80, 27'h4000000, 27'h2000000, 27'h2000000, 3};
    vecs[2] = '{32'h4B800000, 32'h3F800001, 1'b0, 1'b0, 1'b0, 8'h97, 27'h4000000, 27'h0000005, 27'h0000004, 8};
    vecs[3] = '{32'h4F800000, 32'h3F800000, 1'b0, 1'b0, 1'b0, 8'h9F, 27'h4000000, 27'h0000001, 27'h0000000, 9};
    vecs[4] = '{32'hBF800000, 32'h40400000, 1'b1, 1'b0, 1'b1, 8'h80, 27'h6000000, 27'h2000000, 27'h2000000, 3};
    vecs[5] = '{32'h00000001, 32'h00800000, 1'b1, 1'b0, 1'b0, 8'h01, 27'h4000000, 27'h0000008, 27'h0000008, 2};
    vecs[6] = '{32'hC0A00000, 32'h40A00000, 1'b0, 1'b1, 1'b1, 8'h81, 27'h5000000, 27'h5000000, 27'h5000000, 2};
    vecs[7] = '{32'h7F800000, 32'h3F800000, 1'b0, 1'b0, 1'b0, 8'hFF, 27'h4000000, 27'h0000001, 27'h0000000, 9};
    vecs[8] = '{32'h41800000, 32'h3F800001, 1'b0, 1'b0, 1'b0, 8'h83, 27'h4000000, 27'h0400001, 27'h0400000, 3};
    vecs[9] = '{32'h42000000, 32'h3F800001, 1'b0, 1'b0, 1'b0, 8'h84, 27'h4000000, 27'h0200001, 27'h0200000, 4};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.x         = '0;
    bus.y         = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready", 32'(bus.in_ready), 32'd0);
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset man_big", 32'(bus.man_big), 32'd0);
    res = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post-reset in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 10; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      send(vecs[i].x, vecs[i].y, lat);
      chk({tag, " latency"}, 32'(lat), 32'(vecs[i].lat));
      chk({tag, " in_ready_busy"}, 32'(bus.in_ready), 32'd0);
      check_outputs(tag, vecs[i]);
      handshake(tag);
    end

    // Back-pressure: outputs must stay frozen while out_ready is low.
    send(vecs[1].x, vecs[1].y, lat);
    chk("stall latency", 32'(lat), 32'd3);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk("stall out_valid", 32'(bus.out_valid), 32'd1);
      chk("stall in_ready", 32'(bus.in_ready), 32'd0);
      check_outputs("stall", vecs[1]);
    end
    handshake("stall");

    // Reset in the middle of the d=24 shift sequence.
    @(negedge clk);
    bus.x        = vecs[2].x;
    bus.y        = vecs[2].y;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("abort pre-reset out_valid", 32'(bus.out_valid), 32'd0);
    res = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort in_ready", 32'(bus.in_ready), 32'd0);
    chk("abort man_small", 32'(bus.man_small), 32'd0);
    chk("abort man_big", 32'(bus.man_big), 32'd0);
    chk("abort exp_out", 32'(bus.exp_out), 32'd0);
    chk("abort swap", 32'(bus.swap), 32'd0);
    res = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort in_ready release", 32'(bus.in_ready), 32'd1);
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("abort no out_valid", 32'(seen), 32'd0);

    send(vecs[0].x, vecs[0].y, lat);
    chk("recover latency", 32'(lat), 32'd2);
    check_outputs("recover", vecs[0]);
    handshake("recover");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
